ej32_mem_arb: RTL and testbench

- Single-port arbiter and burst sequencer for the eJ32 8-bit SRAM bus.
- Shares the bus between three requesters: ROM-copy loader, load/store unit and instruction fetch.
- Sequences multi-byte load/store bursts (2-byte short, 4-byte int) with an auto-incrementing address.
- Returns read data tagged by source, and has a starvation guard so fetch progresses under heavy load/store traffic.

---
 rtl/ej32_mem_arb_if.sv | 46 ++++
 rtl/ej32_mem_arb.sv | 161 ++++++++++++++++
 tb/tb_ej32_mem_arb.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ej32_mem_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ej32_mem_arb_if : requester, SRAM and read-return bundle for the     |
// |                   eJ32 8-bit SRAM arbiter.                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ej32_mem_arb_if #(
    parameter int ASZ = 17
);
    logic           rom_req;
    logic [ASZ-1:0] rom_a;
    logic [7:0]     rom_d;
    logic           rom_gnt;
    logic           ls_req;
    logic           ls_we;
    logic [1:0]     ls_len;
    logic [ASZ-1:0] ls_a;
    logic [7:0]     ls_d;
    logic           ls_gnt;
    logic           if_req;
    logic [ASZ-1:0] if_a;
    logic           if_gnt;
    logic [ASZ-1:0] mem_a;
    logic           mem_we;
    logic [7:0]     mem_d;
    logic [7:0]     mem_q;
    logic           rd_vld;
    logic [1:0]     rd_src;
    logic [7:0]     rd_d;
    logic           busy;

    modport slave (
        input  rom_req, rom_a, rom_d, ls_req, ls_we, ls_len, ls_a, ls_d,
               if_req, if_a, mem_q,
        output rom_gnt, ls_gnt, if_gnt, mem_a, mem_we, mem_d,
               rd_vld, rd_src, rd_d, busy
    );

    modport master (
        output rom_req, rom_a, rom_d, ls_req, ls_we, ls_len, ls_a, ls_d,
               if_req, if_a, mem_q,
        input  rom_gnt, ls_gnt, if_gnt, mem_a, mem_we, mem_d,
               rd_vld, rd_src, rd_d, busy
    );
endinterface
`default_nettype wire

// File: rtl/ej32_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ej32_mem_arb : single-port SRAM arbiter and load/store burst         |
// |                sequencer with fetch starvation guard.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ej32_mem_arb #(
    parameter int ASZ    = 17,
    parameter int STARVE = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ej32_mem_arb_if.slave     bus
);

    localparam int             c_WW       = $clog2(STARVE + 1);
    localparam logic [c_WW-1:0] c_STARVE  = c_WW'(STARVE);
    localparam logic [c_WW-1:0] c_WONE    = c_WW'(1);
    localparam logic [ASZ-1:0]  c_AONE    = ASZ'(1);
    localparam logic [1:0]      c_SRC_NONE = 2'd0;
    localparam logic [1:0]      c_SRC_LS   = 2'd1;
    localparam logic [1:0]      c_SRC_IF   = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_cnt;
    logic [ASZ-1:0]  r_a;
    logic            r_we;
    logic [c_WW-1:0] r_if_wait;
    logic            r_rd_vld;
    logic [1:0]      r_rd_src;

    state_t          w_state_nxt;
    logic [1:0]      w_cnt_nxt;
    logic [ASZ-1:0]  w_a_nxt;
    logic            w_we_nxt;
    logic            w_rom_gnt;
    logic            w_ls_gnt;
    logic            w_if_gnt;
    logic [ASZ-1:0]  w_mem_a;
    logic            w_mem_we;
    logic [7:0]      w_mem_d;
    logic            w_if_prio;

    // A starved fetch outranks load/store but never the ROM loader.
    assign w_if_prio = bus.if_req && (r_if_wait == c_STARVE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_we_nxt    = r_we;
        w_rom_gnt   = 1'b0;
        w_ls_gnt    = 1'b0;
        w_if_gnt    = 1'b0;
        w_mem_a     = '0;
        w_mem_we    = 1'b0;
        w_mem_d     = 8'h00;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rom_req) begin
                        w_rom_gnt = 1'b1;
                        w_mem_a   = bus.rom_a;
                        w_mem_we  = 1'b1;
                        w_mem_d   = bus.rom_d;
                    end else if (w_if_prio) begin
                        w_if_gnt = 1'b1;
                        w_mem_a  = bus.if_a;
                    end else if (bus.ls_req) begin
                        w_ls_gnt = 1'b1;
                        w_mem_a  = bus.ls_a;
                        w_mem_we = bus.ls_we;
                        w_mem_d  = bus.ls_d;
                        if (bus.ls_len != 2'd0) begin
                            w_state_nxt = S_BURST;
                            w_cnt_nxt   = bus.ls_len;
                            w_a_nxt     = bus.ls_a + c_AONE;
                            w_we_nxt    = bus.ls_we;
                        end
                    end else if (bus.if_req) begin
                        w_if_gnt = 1'b1;
                        w_mem_a  = bus.if_a;
                    end
                end
                S_BURST: begin
                    w_ls_gnt  = 1'b1;
                    w_mem_a   = r_a;
                    w_mem_we  = r_we;
                    w_mem_d   = bus.ls_d;
                    w_a_nxt   = r_a + c_AONE;
                    w_cnt_nxt = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_a     <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_we    <= w_we_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_wait <= '0;
        end else if (bus.if_req && !w_if_gnt) begin
            if (r_if_wait != c_STARVE) begin
                r_if_wait <= r_if_wait + c_WONE;
            end
        end else begin
            r_if_wait <= '0;
        end
    end

    // SRAM read data arrives one cycle after the address; tag it here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld <= 1'b0;
            r_rd_src <= c_SRC_NONE;
        end else if (w_if_gnt) begin
            r_rd_vld <= 1'b1;
            r_rd_src <= c_SRC_IF;
        end else if (w_ls_gnt && !w_mem_we) begin
            r_rd_vld <= 1'b1;
            r_rd_src <= c_SRC_LS;
        end else begin
            r_rd_vld <= 1'b0;
            r_rd_src <= c_SRC_NONE;
        end
    end

    assign bus.rom_gnt = w_rom_gnt;
    assign bus.ls_gnt  = w_ls_gnt;
    assign bus.if_gnt  = w_if_gnt;
    assign bus.mem_a   = w_mem_a;
    assign bus.mem_we  = w_mem_we;
    assign bus.mem_d   = w_mem_d;
    assign bus.rd_vld  = r_rd_vld;
    assign bus.rd_src  = r_rd_src;
    assign bus.rd_d    = bus.mem_q;
    assign bus.busy    = (r_state == S_BURST) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_ej32_mem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ej32_mem_arb : scoreboard bench for the eJ32 SRAM arbiter.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ej32_mem_arb;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [9:0] exp_q[$];
    logic [9:0] exp;

    ej32_mem_arb_if #(.ASZ(17)) bus ();

    ej32_mem_arb #(.ASZ(17), .STARVE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rom_req = 1'b0; bus.rom_a = '0; bus.rom_d = 8'h00;
        bus.ls_req  = 1'b0; bus.ls_we = 1'b0; bus.ls_len = 2'd0;
        bus.ls_a    = '0;   bus.ls_d  = 8'h00;
        bus.if_req  = 1'b0; bus.if_a  = '0; bus.mem_q = 8'h00;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.rom_req = 1'b1; bus.ls_req = 1'b1; bus.if_req = 1'b1;
        bus.rom_a = 17'h00123; bus.rom_d = 8'hEE;
        @(negedge clk);
        n_chk++;
        if ({bus.rom_gnt, bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.busy, bus.mem_a, bus.mem_d} !== 30'h0) begin
            n_err++;
            $display("FAIL reset_forced: got gnt=%b%b%b we=%b busy=%b a=%h d=%h want all 0",
                     bus.rom_gnt, bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.busy, bus.mem_a, bus.mem_d);
        end
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.rom_gnt, bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.busy, bus.rd_vld, bus.rd_src} !== 8'h0) begin
            n_err++;
            $display("FAIL reset_idle: got gnt=%b%b%b we=%b busy=%b vld=%b src=%0d want all 0",
                     bus.rom_gnt, bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.busy, bus.rd_vld, bus.rd_src);
        end
        next_cycle();
    endtask

    task automatic test_ls_read();
        logic [7:0]  data [4];
        logic [16:0] ea;
        data = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_len = 2'd3; bus.ls_a = 17'h00100;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) bus.ls_req = 1'b0;
            if (k > 0) bus.mem_q = data[k-1];
            @(negedge clk);
            if (k < 4) begin
                ea = 17'h00100 + 17'(k);
                n_chk++;
                if ({bus.ls_gnt, bus.mem_we, bus.busy, bus.mem_a} !== {1'b1, 1'b0, (k > 0), ea}) begin
                    n_err++;
                    $display("FAIL rd_beat[%0d]: got gnt=%b we=%b busy=%b a=%h want 1 0 %b %h",
                             k, bus.ls_gnt, bus.mem_we, bus.busy, bus.mem_a, (k > 0), ea);
                end
                exp_q.push_back({2'd1, data[k]});
            end else begin
                n_chk++;
                if ({bus.ls_gnt, bus.busy} !== 2'b00) begin
                    n_err++;
                    $display("FAIL rd_end: got gnt=%b busy=%b want 0 0", bus.ls_gnt, bus.busy);
                end
            end
            if (k > 0) begin
                if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
                n_chk++;
                if ({bus.rd_vld, bus.rd_src, bus.rd_d} !== {1'b1, exp}) begin
                    n_err++;
                    $display("FAIL rd_data[%0d]: got vld=%b src=%0d d=%h want 1 %0d %h",
                             k, bus.rd_vld, bus.rd_src, bus.rd_d, exp[9:8], exp[7:0]);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        n_chk++;
        if (bus.rd_vld !== 1'b0) begin
            n_err++;
            $display("FAIL rd_tail_vld: got %b want 0", bus.rd_vld);
        end
        next_cycle();
    endtask

    task automatic test_ls_write_wrap();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_len = 2'd1;
        bus.ls_a = 17'h1FFFF; bus.ls_d = 8'hAB;
        @(negedge clk);
        n_chk++;
        if ({bus.ls_gnt, bus.mem_we, bus.busy, bus.mem_a, bus.mem_d} !== {3'b110, 17'h1FFFF, 8'hAB}) begin
            n_err++;
            $display("FAIL wr_beat0: got gnt=%b we=%b busy=%b a=%h d=%h want 1 1 0 1ffff ab",
                     bus.ls_gnt, bus.mem_we, bus.busy, bus.mem_a, bus.mem_d);
        end
        next_cycle();
        bus.ls_req = 1'b0; bus.ls_d = 8'hCD;
        @(negedge clk);
        n_chk++;
        if ({bus.ls_gnt, bus.mem_we, bus.busy, bus.rd_vld, bus.mem_a, bus.mem_d} !== {4'b1110, 17'h00000, 8'hCD}) begin
            n_err++;
            $display("FAIL wr_beat1_wrap: got gnt=%b we=%b busy=%b vld=%b a=%h d=%h want 1 1 1 0 00000 cd",
                     bus.ls_gnt, bus.mem_we, bus.busy, bus.rd_vld, bus.mem_a, bus.mem_d);
        end
        next_cycle();
        bus.ls_we = 1'b0; bus.ls_d = 8'h00;
        @(negedge clk);
        n_chk++;
        if ({bus.ls_gnt, bus.busy, bus.rd_vld} !== 3'b000) begin
            n_err++;
            $display("FAIL wr_end: got gnt=%b busy=%b vld=%b want 0 0 0", bus.ls_gnt, bus.busy, bus.rd_vld);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        bus.rom_req = 1'b1; bus.rom_a = 17'h00055; bus.rom_d = 8'h5A;
        bus.ls_req  = 1'b1; bus.ls_we = 1'b0; bus.ls_len = 2'd0; bus.ls_a = 17'h00200;
        bus.if_req  = 1'b1; bus.if_a  = 17'h00300;
        @(negedge clk);
        n_chk++;
        if ({bus.rom_gnt, bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.mem_a, bus.mem_d} !== {4'b1001, 17'h00055, 8'h5A}) begin
            n_err++;
            $display("FAIL prio_rom: got gnt=%b%b%b we=%b a=%h d=%h want 100 1 00055 5a",
                     bus.rom_gnt, bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.mem_a, bus.mem_d);
        end
        next_cycle();
        bus.rom_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.rom_gnt, bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.rd_vld, bus.mem_a} !== {5'b01000, 17'h00200}) begin
            n_err++;
            $display("FAIL prio_ls: got gnt=%b%b%b we=%b vld=%b a=%h want 010 0 0 00200",
                     bus.rom_gnt, bus.ls_gnt, bus.if_gnt, bus.mem_we, bus.rd_vld, bus.mem_a);
        end
        exp_q.push_back({2'd1, 8'h77});
        next_cycle();
        bus.ls_req = 1'b0; bus.mem_q = 8'h77;
        @(negedge clk);
        n_chk++;
        if ({bus.if_gnt, bus.mem_we, bus.mem_a, bus.mem_d} !== {2'b10, 17'h00300, 8'h00}) begin
            n_err++;
            $display("FAIL prio_if: got gnt=%b we=%b a=%h d=%h want 1 0 00300 00",
                     bus.if_gnt, bus.mem_we, bus.mem_a, bus.mem_d);
        end
        if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
        n_chk++;
        if ({bus.rd_vld, bus.rd_src, bus.rd_d} !== {1'b1, exp}) begin
            n_err++;
            $display("FAIL prio_rd_ls: got vld=%b src=%0d d=%h want 1 %0d %h",
                     bus.rd_vld, bus.rd_src, bus.rd_d, exp[9:8], exp[7:0]);
        end
        exp_q.push_back({2'd2, 8'h99});
        next_cycle();
        bus.if_req = 1'b0; bus.mem_q = 8'h99;
        @(negedge clk);
        if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
        n_chk++;
        if ({bus.rd_vld, bus.rd_src, bus.rd_d} !== {1'b1, exp}) begin
            n_err++;
            $display("FAIL prio_rd_if: got vld=%b src=%0d d=%h want 1 %0d %h",
                     bus.rd_vld, bus.rd_src, bus.rd_d, exp[9:8], exp[7:0]);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [7:0] q;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_len = 2'd0; bus.ls_a = 17'h00400;
        bus.if_req = 1'b1; bus.if_a = 17'h00500;
        // cycles 0..3: ls wins; 4: starved fetch wins; 5: counter cleared, ls again
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                bus.ls_req = 1'b0; bus.if_req = 1'b0;
            end
            if (k > 0) bus.mem_q = 8'h60 + 8'(k - 1);
            @(negedge clk);
            if (k < 6) begin
                n_chk++;
                if ({bus.ls_gnt, bus.if_gnt} !== ((k == 4) ? 2'b01 : 2'b10)) begin
                    n_err++;
                    $display("FAIL starve_gnt[%0d]: got ls=%b if=%b want %b",
                             k, bus.ls_gnt, bus.if_gnt, (k == 4) ? 2'b01 : 2'b10);
                end
                q = 8'h60 + 8'(k);
                exp_q.push_back({((k == 4) ? 2'd2 : 2'd1), q});
            end
            if (k > 0) begin
                if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
                n_chk++;
                if ({bus.rd_vld, bus.rd_src, bus.rd_d} !== {1'b1, exp}) begin
                    n_err++;
                    $display("FAIL starve_rd[%0d]: got vld=%b src=%0d d=%h want 1 %0d %h",
                             k, bus.rd_vld, bus.rd_src, bus.rd_d, exp[9:8], exp[7:0]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_burst();
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_len = 2'd3; bus.ls_a = 17'h00600;
        @(negedge clk);
        exp_q.push_back({2'd1, 8'h21});
        next_cycle();
        bus.ls_req = 1'b0; bus.mem_q = 8'h21;
        #2;
        n_chk++;
        if ({bus.ls_gnt, bus.busy, bus.mem_a} !== {2'b11, 17'h00601}) begin
            n_err++;
            $display("FAIL mid_beat2: got gnt=%b busy=%b a=%h want 1 1 00601",
                     bus.ls_gnt, bus.busy, bus.mem_a);
        end
        if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
        n_chk++;
        if ({bus.rd_vld, bus.rd_src, bus.rd_d} !== {1'b1, exp}) begin
            n_err++;
            $display("FAIL mid_rd: got vld=%b src=%0d d=%h want 1 %0d %h",
                     bus.rd_vld, bus.rd_src, bus.rd_d, exp[9:8], exp[7:0]);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.ls_gnt, bus.busy, bus.rd_vld, bus.mem_a} !== {3'b000, 17'h0}) begin
            n_err++;
            $display("FAIL mid_rst: got gnt=%b busy=%b vld=%b a=%h want 0 0 0 00000",
                     bus.ls_gnt, bus.busy, bus.rd_vld, bus.mem_a);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.ls_gnt, bus.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_after: got gnt=%b busy=%b want 0 0", bus.ls_gnt, bus.busy);
        end
        next_cycle();
        bus.ls_req = 1'b1; bus.ls_len = 2'd0; bus.ls_a = 17'h00700;
        @(negedge clk);
        n_chk++;
        if ({bus.ls_gnt, bus.busy, bus.mem_a} !== {2'b10, 17'h00700}) begin
            n_err++;
            $display("FAIL mid_restart: got gnt=%b busy=%b a=%h want 1 0 00700",
                     bus.ls_gnt, bus.busy, bus.mem_a);
        end
        exp_q.push_back({2'd1, 8'h42});
        next_cycle();
        bus.ls_req = 1'b0; bus.mem_q = 8'h42;
        @(negedge clk);
        if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 'x;
        n_chk++;
        if ({bus.rd_vld, bus.rd_src, bus.rd_d, bus.ls_gnt} !== {1'b1, exp, 1'b0}) begin
            n_err++;
            $display("FAIL mid_restart_rd: got vld=%b src=%0d d=%h gnt=%b want 1 %0d %h 0",
                     bus.rd_vld, bus.rd_src, bus.rd_d, bus.ls_gnt, exp[9:8], exp[7:0]);
        end
        next_cycle();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_inputs();
        next_cycle();
        test_reset();
        test_ls_read();
        test_ls_write_wrap();
        test_priority();
        test_starvation();
        test_reset_mid_burst();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
